// File: rtl/inst_fetcher_pkg.sv
// Shared widths, opcode constants, IF-stage state encoding and JAL immediate helper.
package inst_fetcher_pkg;

  localparam int unsigned INS_LEN    = 32;
  localparam int unsigned ADDR_LEN   = 32;
  localparam int unsigned OPCODE_MSB = 6;
  localparam int unsigned OPCODE_LSB = 0;

  localparam logic [OPCODE_MSB:OPCODE_LSB] OPCODE_JAL = 7'b1101111;
  localparam logic [INS_LEN-1:0]           ZERO_WORD  = '0;
  localparam logic                         TRUE       = 1'b1;
  localparam logic                         FALSE      = 1'b0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDrop = 2'd2
  } if_state_e;

  // J-type immediate, sign-extended to a full address offset.
  function automatic logic [ADDR_LEN-1:0] jal_offset(logic [INS_LEN-1:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/inst_queue.sv
// Circular FIFO of {pc, inst} pairs feeding the decoder; head reads as zero when empty.
module inst_queue
  import inst_fetcher_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  input  logic                clear,
  input  logic [ADDR_LEN-1:0] push_pc,
  input  logic [INS_LEN-1:0]  push_inst,
  output logic                full,
  output logic                empty,
  output logic [ADDR_LEN-1:0] head_pc,
  output logic [INS_LEN-1:0]  head_inst
);

  localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0]     head_q, tail_q;
  logic [CntW-1:0]     count_q;
  logic [ADDR_LEN-1:0] pc_mem   [QUEUE_DEPTH];
  logic [INS_LEN-1:0]  inst_mem [QUEUE_DEPTH];
  logic                do_push, do_pop;

  assign full    = (count_q == CntW'(QUEUE_DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !clear;
  assign do_pop  = pop && !clear && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (clear) begin
      head_q  <= tail_q;
      count_q <= '0;
    end else begin
      if (do_push) tail_q <= tail_q + 1'b1;
      if (do_pop)  head_q <= head_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      pc_mem[tail_q]   <= push_pc;
      inst_mem[tail_q] <= push_inst;
    end
  end

  assign head_pc   = empty ? ZERO_WORD : pc_mem[head_q];
  assign head_inst = empty ? ZERO_WORD : inst_mem[head_q];

endmodule

// File: rtl/inst_fetcher.sv
// IF stage: PC, single-outstanding fetch FSM, flush redirect and instruction queue.
// Define IF_JAL_PREDECODE_EN to redirect the PC on fetched JALs without waiting for a flush.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int unsigned         QUEUE_DEPTH = 16,
  parameter logic [ADDR_LEN-1:0] RESET_PC    = 32'h0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  output logic                mem_req,
  output logic [ADDR_LEN-1:0] mem_addr,
  input  logic                mem_valid,
  input  logic [INS_LEN-1:0]  mem_inst,
  output logic                if_valid,
  output logic [INS_LEN-1:0]  if_inst,
  output logic [ADDR_LEN-1:0] if_pc,
  input  logic                id_ready,
  input  logic                flush,
  input  logic [ADDR_LEN-1:0] flush_pc
);

`ifdef IF_JAL_PREDECODE_EN
  localparam bit JalEn = 1'b1;
`else
  localparam bit JalEn = 1'b0;
`endif

  if_state_e           state_q, state_d;
  logic [ADDR_LEN-1:0] pc_q, pc_d;
  logic [ADDR_LEN-1:0] req_pc_q, req_pc_d;
  logic [ADDR_LEN-1:0] mem_addr_q, mem_addr_d;
  logic                mem_req_q, mem_req_d;
  logic                q_push, q_pop, q_clear, q_full, q_empty;
  logic                is_jal;
  logic [ADDR_LEN-1:0] next_pc;

  assign is_jal  = (mem_inst[OPCODE_MSB:OPCODE_LSB] == OPCODE_JAL);
  assign next_pc = (JalEn && is_jal) ? req_pc_q + jal_offset(mem_inst) : req_pc_q + 32'd4;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    q_push     = FALSE;
    q_pop      = FALSE;
    q_clear    = FALSE;
    if (rdy) begin
      if (flush) begin
        q_clear = TRUE;
        pc_d    = flush_pc;
        // An in-flight request must still be absorbed, so its reply is tracked in StDrop.
        case (state_q)
          StIdle: state_d = StIdle;
          StWait, StDrop: begin
            if (mem_valid) begin
              state_d   = StIdle;
              mem_req_d = FALSE;
            end else begin
              state_d = StDrop;
            end
          end
          default: state_d = StIdle;
        endcase
      end else begin
        q_pop = !q_empty && id_ready;
        case (state_q)
          StIdle: begin
            if (!q_full) begin
              mem_req_d  = TRUE;
              mem_addr_d = pc_q;
              req_pc_d   = pc_q;
              state_d    = StWait;
            end
          end
          StWait: begin
            if (mem_valid) begin
              mem_req_d = FALSE;
              q_push    = TRUE;
              pc_d      = next_pc;
              state_d   = StIdle;
            end
          end
          StDrop: begin
            if (mem_valid) begin
              mem_req_d = FALSE;
              state_d   = StIdle;
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      mem_req_q  <= FALSE;
      mem_addr_q <= '0;
    end else if (rdy) begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  inst_queue #(
    .QUEUE_DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (q_push),
    .pop      (q_pop),
    .clear    (q_clear),
    .push_pc  (req_pc_q),
    .push_inst(mem_inst),
    .full     (q_full),
    .empty    (q_empty),
    .head_pc  (if_pc),
    .head_inst(if_inst)
  );

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign if_valid = !q_empty;

endmodule

// File: tb/tb_inst_fetcher.sv
// Self-checking bench for inst_fetcher (QUEUE_DEPTH=4): fetch table, full queue, flushes, JAL, rdy, rst.
module tb_inst_fetcher;

  logic        clk = 1'b0;
  logic        rst, rdy, mem_req, mem_valid, if_valid, id_ready, flush;
  logic [31:0] mem_addr, mem_inst, if_inst, if_pc, flush_pc;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  inst_fetcher #(
    .QUEUE_DEPTH(4),
    .RESET_PC   (32'h0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_valid(mem_valid),
    .mem_inst (mem_inst),
    .if_valid (if_valid),
    .if_inst  (if_inst),
    .if_pc    (if_pc),
    .id_ready (id_ready),
    .flush    (flush),
    .flush_pc (flush_pc)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } sb_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
  } vec_t;

  sb_t  sb_q[$];
  vec_t tbl[6];
  logic [31:0] exp5;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare the head against the scoreboard whenever the coming edge pops it.
  task automatic tick();
    sb_t e;
    if (!rst && rdy && !flush && if_valid && id_ready) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL pop_unexpected: got pc %h, expected no entry", if_pc);
      end else begin
        e = sb_q.pop_front();
        check("pop_pc", if_pc, e.pc);
        check("pop_inst", if_inst, e.inst);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int k = 0;
    while (!mem_req && k < 20) begin
      tick();
      k++;
    end
    if (!mem_req) begin
      n_tests++;
      n_fail++;
      $display("FAIL req_timeout: mem_req got 0 expected 1");
    end
  endtask

  // Two-cycle memory: one wait cycle, then a one-cycle mem_valid pulse.
  task automatic respond(input logic [31:0] word, input bit accept, input logic [31:0] pc);
    tick();
    mem_valid = 1'b1;
    mem_inst  = word;
    if (accept) sb_q.push_back('{pc: pc, inst: word});
    tick();
    mem_valid = 1'b0;
    mem_inst  = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_req"}, {31'b0, mem_req}, 32'h0);
    check({tag, "_mem_addr"}, mem_addr, 32'h0);
    check({tag, "_if_valid"}, {31'b0, if_valid}, 32'h0);
    check({tag, "_if_inst"}, if_inst, 32'h0);
    check({tag, "_if_pc"}, if_pc, 32'h0);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; mem_valid = 1'b0; mem_inst = '0;
    id_ready = 1'b0; flush = 1'b0; flush_pc = '0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;

    tbl[0] = '{inst: 32'h00000013, addr: 32'h0};
    tbl[1] = '{inst: 32'h00000013, addr: 32'h4};
    tbl[2] = '{inst: 32'h0080006F, addr: 32'h8};
`ifdef IF_JAL_PREDECODE_EN
    tbl[3] = '{inst: 32'h00000013, addr: 32'h10};
    tbl[4] = '{inst: 32'hFF9FF06F, addr: 32'h14};
    tbl[5] = '{inst: 32'h00000013, addr: 32'h0C};
    exp5   = 32'h8;
`else
    tbl[3] = '{inst: 32'h00000013, addr: 32'h0C};
    tbl[4] = '{inst: 32'hFF9FF06F, addr: 32'h10};
    tbl[5] = '{inst: 32'h00000013, addr: 32'h14};
    exp5   = 32'h4;
`endif

    // Streaming fetch with a consumer that is always ready.
    id_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_req();
      check("t1_req_addr", mem_addr, tbl[i].addr);
      respond(tbl[i].inst, 1'b1, tbl[i].addr);
    end
    repeat (4) tick();
    check("t1_drain", 32'(sb_q.size()), 32'h0);

    // Fill a 4-entry queue with the consumer stalled.
    rst = 1'b1; id_ready = 1'b0;
    tick();
    rst = 1'b0;
    sb_q.delete();
    for (int k = 0; k < 4; k++) begin
      wait_req();
      check("t2_req_addr", mem_addr, 32'(4 * k));
      respond(32'h00000013, 1'b1, 32'(4 * k));
    end
    begin
      bit saw = 1'b0;
      repeat (10) begin
        tick();
        if (mem_req) saw = 1'b1;
      end
      check("t2_no_req_when_full", {31'b0, saw}, 32'h0);
    end
    check("t2_head_valid", {31'b0, if_valid}, 32'h1);
    check("t2_head_pc", if_pc, 32'h0);
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    wait_req();
    check("t2_refill_addr", mem_addr, 32'h10);
    respond(32'h00000013, 1'b1, 32'h10);

    // Flush while a request is outstanding: the late reply is discarded.
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    wait_req();
    check("t3_wait_addr", mem_addr, 32'h14);
    flush = 1'b1; flush_pc = 32'h100;
    tick();
    flush = 1'b0;
    sb_q.delete();
    check("t3_flush_empty", {31'b0, if_valid}, 32'h0);
    check("t3_drop_req", {31'b0, mem_req}, 32'h1);
    check("t3_drop_addr_hold", mem_addr, 32'h14);
    respond(32'h00000013, 1'b0, 32'h14);
    check("t3_dropped", {31'b0, if_valid}, 32'h0);
    wait_req();
    check("t3_redirect", mem_addr, 32'h100);

    // Flush coinciding with a reply and a pop, three entries queued.
    respond(32'h00000013, 1'b1, 32'h100);
    wait_req();
    respond(32'h00000013, 1'b1, 32'h104);
    wait_req();
    respond(32'h00000013, 1'b1, 32'h108);
    wait_req();
    check("t4_wait_addr", mem_addr, 32'h10C);
    check("t4_head_pc", if_pc, 32'h100);
    tick();
    mem_valid = 1'b1; mem_inst = 32'h00000013; id_ready = 1'b1;
    flush = 1'b1; flush_pc = 32'h200;
    tick();
    mem_valid = 1'b0; id_ready = 1'b0; flush = 1'b0;
    sb_q.delete();
    check("t4_empty", {31'b0, if_valid}, 32'h0);
    check("t4_req_low", {31'b0, mem_req}, 32'h0);
    wait_req();
    check("t4_redirect", mem_addr, 32'h200);
    id_ready = 1'b1;
    respond(32'h00000013, 1'b1, 32'h200);
    repeat (3) tick();
    check("t4_drain", 32'(sb_q.size()), 32'h0);

    // JAL fetched at 0x0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_q.delete();
    wait_req();
    check("t5_addr", mem_addr, 32'h0);
    respond(32'h0080006F, 1'b1, 32'h0);
    wait_req();
    check("t5_next_addr", mem_addr, exp5);

    // rdy low mid-wait: replies and pops are ignored, everything holds.
    id_ready = 1'b0;
    respond(32'h00000013, 1'b1, exp5);
    wait_req();
    check("t6_addr", mem_addr, exp5 + 32'h4);
    tick();
    rdy = 1'b0; id_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mem_valid = (i % 2 == 0);
      mem_inst  = 32'hDEADBEEF;
      tick();
      check("t6_hold_req", {31'b0, mem_req}, 32'h1);
      check("t6_hold_addr", mem_addr, exp5 + 32'h4);
      check("t6_hold_valid", {31'b0, if_valid}, 32'h1);
      check("t6_hold_pc", if_pc, exp5);
      check("t6_hold_inst", if_inst, 32'h00000013);
    end
    rdy = 1'b1; mem_valid = 1'b0; mem_inst = '0; id_ready = 1'b0;
    respond(32'h00000033, 1'b1, exp5 + 32'h4);
    wait_req();
    check("t6_pc_kept", mem_addr, exp5 + 32'h8);

    // Reset while waiting on memory.
    rst = 1'b1;
    tick();
    check_reset_outputs("t6_rst");
    rst = 1'b0;
    sb_q.delete();
    wait_req();
    check("t6_after_rst", mem_addr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
